solve_host_if: RTL and testbench

//  Host-side counterpart of the solver top. Host writes the 120-bit cube state
//  as four 32-bit words and issues a start. The block pulses run and holds the

---
 rtl/solve_host_if.sv | 171 +++++++++++++++++
 tb/tb_solve_host_if.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/solve_host_if.sv
// rtl/solve_host_if.sv - host register port, solver launcher and solution move recorder
module solve_host_if #(
    parameter int CUBE_W      = 120,
    parameter int MOVE_W      = 4,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [2:0]        rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              run,
    output logic [CUBE_W-1:0] cube_d,
    input  logic [3:0]        sol_addr,
    input  logic [MOVE_W-1:0] sol_step,
    input  logic              sol_done,
    output logic              irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DONE, S_FAIL} state_t;
    state_t state_q, state_d;

    logic [CUBE_W-1:0] cube_q;
    logic [3:0]        prev_addr_q;
    logic              done_q;
    logic [15:0]       timer_q;
    logic              skid_q;
    logic              skid_push_q;
    logic [MOVE_W-1:0] skid_data_q;
    logic [MOVE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              ovf_q;

    logic              ctrl_wr;
    logic              clear;
    logic              start_go;
    logic              in_run;
    logic              addr_chg;
    logic              done_rise;
    logic              push;
    logic              pop;
    logic              do_push;
    logic [MOVE_W-1:0] push_data;
    logic [31:0]       rd_mux;

    assign ctrl_wr   = wr_en && (wr_addr == 3'd4);
    assign clear     = ctrl_wr && wr_data[1];
    assign start_go  = ctrl_wr && wr_data[0] && !wr_data[1] && (state_q == S_IDLE);
    assign in_run    = (state_q == S_RUN);
    assign addr_chg  = (sol_addr != prev_addr_q);
    assign done_rise = sol_done && !done_q;
    assign run       = (state_q == S_ARM);
    assign irq       = (state_q == S_DONE) || (state_q == S_FAIL);
    assign cube_d    = cube_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_go) state_d = S_ARM;
            S_ARM:  state_d = S_RUN;
            S_RUN: begin
                // A done rise that coincides with an addr change waits one cycle in the skid
                if (skid_q)                    state_d = S_DONE;
                else if (done_rise)            state_d = addr_chg ? S_RUN : S_DONE;
                else if (timer_q == TMO_LAST)  state_d = S_FAIL;
            end
            default: ;
        endcase
        if (clear) state_d = S_IDLE;
    end

    always_comb begin
        push      = 1'b0;
        push_data = sol_step;
        if (in_run) begin
            if (skid_q) begin
                push      = skid_push_q;
                push_data = skid_data_q;
            end else if (addr_chg) begin
                push = (prev_addr_q != 4'd0);
            end else if (done_rise) begin
                push = (sol_addr != 4'd0);
            end
        end
    end

    assign pop     = rd_en && (rd_addr == 3'd6) && (count_q != '0);
    assign do_push = push && ((count_q != FULL_CNT) || pop);

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            3'd0: rd_mux = cube_q[31:0];
            3'd1: rd_mux = cube_q[63:32];
            3'd2: rd_mux = cube_q[95:64];
            3'd3: rd_mux = {8'd0, cube_q[119:96]};
            3'd5: rd_mux = {22'd0, ovf_q, state_q == S_FAIL, state_q == S_DONE, in_run, 6'(count_q)};
            3'd6: if (count_q != '0) rd_mux = 32'(mem[rd_ptr_q]);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cube_q      <= '0;
            prev_addr_q <= '0;
            done_q      <= 1'b0;
            timer_q     <= '0;
            skid_q      <= 1'b0;
            skid_push_q <= 1'b0;
            skid_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= sol_done;
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
            if (wr_en && (state_q == S_IDLE)) begin
                case (wr_addr)
                    3'd0: cube_q[31:0]   <= wr_data;
                    3'd1: cube_q[63:32]  <= wr_data;
                    3'd2: cube_q[95:64]  <= wr_data;
                    3'd3: cube_q[119:96] <= wr_data[23:0];
                    default: ;
                endcase
            end
            if (start_go) begin
                prev_addr_q <= '0;
                timer_q     <= '0;
                skid_q      <= 1'b0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                ovf_q       <= 1'b0;
            end else begin
                if (in_run) begin
                    timer_q     <= timer_q + 16'd1;
                    if (!skid_q && addr_chg) prev_addr_q <= sol_addr;
                    skid_q      <= !skid_q && done_rise && addr_chg;
                    skid_push_q <= (sol_addr != 4'd0);
                    skid_data_q <= sol_step;
                end
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
                if (do_push != pop) count_q <= do_push ? count_q + CW'(1) : count_q - CW'(1);
                if (push && !do_push) ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end
endmodule

// File: tb/tb_solve_host_if.sv
// tb/tb_solve_host_if.sv - self-checking bench for solve_host_if
`timescale 1ns/1ps
module tb_solve_host_if;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic         rd_en = 1'b0;
    logic [2:0]   rd_addr = '0;
    logic [31:0]  rd_data;
    logic         rd_valid;
    logic         run;
    logic [119:0] cube_d;
    logic [3:0]   sol_addr = '0;
    logic [3:0]   sol_step = '0;
    logic         sol_done = 1'b0;
    logic         irq;

    solve_host_if #(.TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .run(run), .cube_d(cube_d),
        .sol_addr(sol_addr), .sol_step(sol_step), .sol_done(sol_done),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2, P_FAIL = 3;
    int           m_phase = P_IDLE;
    logic [119:0] m_cube = '0;
    logic         m_run = 1'b0;
    logic         m_irq = 1'b0;
    logic         m_ovf = 1'b0;
    logic         mon_on = 1'b0;
    int           m_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_status();
        return {22'd0, m_ovf, m_phase == P_FAIL, m_phase == P_DONE, m_phase == P_RUN, 6'(m_q.size())};
    endfunction

    task automatic m_push(input int s);
        if (m_q.size() < 16) m_q.push_back(s);
        else m_ovf = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
        if (m_phase == P_IDLE) begin
            case (a)
                3'd0: m_cube[31:0]   = d;
                3'd1: m_cube[63:32]  = d;
                3'd2: m_cube[95:64]  = d;
                3'd3: m_cube[119:96] = d[23:0];
                default: ;
            endcase
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        rd_en = 1'b1; rd_addr = a;
        cyc();
        rd_en = 1'b0;
        chk("rd_valid", rd_valid, 1'b1);
        d = rd_data;
    endtask

    task automatic status_chk(input string name, input logic [31:0] lit);
        logic [31:0] d;
        rd(3'd5, d);
        chk(name, d, lit);
        chk({name, "_model"}, d, m_status());
    endtask

    task automatic pop_chk(input string name);
        logic [31:0] d;
        int e;
        rd(3'd6, d);
        e = (m_q.size() != 0) ? m_q.pop_front() : 0;
        chk(name, d, e);
    endtask

    task automatic pop_lit(input string name, input int lit);
        logic [31:0] d;
        int e;
        rd(3'd6, d);
        e = (m_q.size() != 0) ? m_q.pop_front() : 0;
        chk(name, d, lit);
        chk({name, "_model"}, d, e);
    endtask

    task automatic start();
        sol_addr = '0; sol_step = '0; sol_done = 1'b0;
        cyc();
        wr(3'd4, 32'h1);
        m_q.delete(); m_ovf = 1'b0; m_run = 1'b1; m_phase = P_RUN;
        chk("run_high", run, 1'b1);
        cyc();
        m_run = 1'b0;
        chk("run_low", run, 1'b0);
    endtask

    // Solver presents the new address first and its move code one cycle later
    task automatic move(input int a, input int s);
        sol_addr = 4'(a);
        cyc();
        sol_step = 4'(s);
        cyc();
        m_push(s);
    endtask

    task automatic finish_done();
        sol_done = 1'b1;
        cyc();
        m_irq = 1'b1; m_phase = P_DONE;
    endtask

    task automatic finish_done_skid(input int a);
        sol_addr = 4'(a); sol_done = 1'b1;
        m_push(int'(sol_step));
        cyc();
        cyc();
        m_irq = 1'b1; m_phase = P_DONE;
    endtask

    task automatic clear();
        wr(3'd4, 32'h2);
        m_irq = 1'b0; m_phase = P_IDLE;
        chk("irq_cleared", irq, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("run_mon", run, m_run);
            chk("irq_mon", irq, m_irq);
            chk("cube_mon", cube_d, m_cube);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        #1 rst = 1'b1;
        #2 mon_on = 1'b1;
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        status_chk("reset_status", 32'h0);

        // cube load, readback, masking and read-before-write ordering
        wr(3'd0, 32'h11111111);
        wr(3'd1, 32'h22222222);
        wr(3'd2, 32'h33333333);
        wr(3'd3, 32'hFFAABBCC);
        chk("cube_loaded", cube_d, 120'hAABBCC_33333333_22222222_11111111);
        rd(3'd3, d); chk("word3", d, 32'h00AABBCC);
        rd(3'd1, d); chk("word1", d, 32'h22222222);
        rd(3'd7, d); chk("unmapped", d, 32'h0);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h55555555;
        rd_en = 1'b1; rd_addr = 3'd0;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        m_cube[31:0] = 32'h55555555;
        chk("rd_old_value", rd_data, 32'h11111111);
        wr(3'd0, 32'h11111111);

        // normal solve of three moves
        start();
        wr(3'd0, 32'hDEADBEEF);
        chk("cube_locked", cube_d[31:0], 32'h11111111);
        status_chk("busy_status", 32'h40);
        move(1, 5); move(2, 9); move(3, 2);
        finish_done();
        status_chk("t2_status", 32'h83);
        pop_lit("t2_pop0", 5);
        pop_lit("t2_pop1", 9);
        pop_lit("t2_pop2", 2);
        pop_lit("t2_pop_empty", 0);
        status_chk("t2_status_empty", 32'h80);
        clear();

        // 18 moves into a 16-entry FIFO
        start();
        for (int i = 1; i <= 18; i++) move(((i - 1) % 15) + 1, (i + 3) % 16);
        finish_done();
        status_chk("t3_status", 32'h290);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("t3_pop%0d", i));
        status_chk("t3_status_empty", 32'h280);
        clear();

        // silent solver times out at RUN cycle 100
        start();
        repeat (99) cyc();
        chk("t4_irq_before", irq, 1'b0);
        cyc();
        m_irq = 1'b1; m_phase = P_FAIL;
        chk("t4_irq_at_timeout", irq, 1'b1);
        status_chk("t4_status", 32'h100);
        clear();

        // addr change and done rise in the same cycle
        start();
        move(1, 5); move(2, 9);
        finish_done_skid(3);
        status_chk("t5_status", 32'h83);
        pop_lit("t5_pop0", 5);
        pop_lit("t5_pop1", 9);
        pop_lit("t5_pop2", 9);
        pop_lit("t5_pop_empty", 0);
        clear();

        // reset in the middle of a solve, then a fresh solve
        start();
        move(1, 3); move(2, 4);
        #2 rst = 1'b1;
        #1;
        chk("t6_run", run, 1'b0);
        chk("t6_irq", irq, 1'b0);
        chk("t6_cube", cube_d, 120'h0);
        chk("t6_rd_data", rd_data, 32'h0);
        chk("t6_rd_valid", rd_valid, 1'b0);
        m_cube = '0; m_q.delete(); m_ovf = 1'b0; m_run = 1'b0; m_irq = 1'b0; m_phase = P_IDLE;
        @(posedge clk);
        #1 rst = 1'b0;
        status_chk("t6_status", 32'h0);
        pop_lit("t6_pop_empty", 0);
        wr(3'd0, 32'h12345678);
        start();
        move(1, 7); move(2, 1);
        finish_done();
        status_chk("t6_status_done", 32'h82);
        pop_lit("t6_pop0", 7);
        pop_lit("t6_pop1", 1);
        clear();

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
